// File: rtl/mem_port_arb_if.sv
// ============================================================================
// Module   : mem_port_arb_if
// Brief    : Fetch, data and memory-port signal bundle for mem_port_arb.
//            The master modport is the arbiter's view; slave is the view of
//            the requesters and memory around it.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arb_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_rdata;

    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        d_misaligned;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        stall;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata,
               mem_ack, mem_rdata,
        output if_valid, if_rdata, d_valid, d_rdata, d_misaligned,
               mem_req, mem_addr, mem_be, mem_wdata, stall
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata,
               mem_ack, mem_rdata,
        input  if_valid, if_rdata, d_valid, d_rdata, d_misaligned,
               mem_req, mem_addr, mem_be, mem_wdata, stall
    );
endinterface

`default_nettype wire

// File: rtl/mem_port_arb.sv
// ============================================================================
// Module   : mem_port_arb
// Brief    : Shares one memory port between instruction fetch and data
//            load/store. Optional macro MEM_ARB_RR_EN: round-robin tie-break.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arb (
    input  logic           clk,
    input  logic           rst_n,
    mem_port_arb_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DATA  = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_mem_req, w_mem_req_nxt;
    logic [31:0] r_mem_addr, w_mem_addr_nxt;
    logic [3:0]  r_mem_be, w_mem_be_nxt;
    logic [31:0] r_mem_wdata, w_mem_wdata_nxt;
    logic        r_if_valid, w_if_valid_nxt;
    logic [31:0] r_if_rdata, w_if_rdata_nxt;
    logic        r_d_valid, w_d_valid_nxt;
    logic [31:0] r_d_rdata, w_d_rdata_nxt;
    logic        r_d_mis, w_d_mis_nxt;

    logic [3:0]  w_st_be;
    logic [31:0] w_st_wdata;
    logic        w_misaligned;
    logic        w_d_first;
    logic        w_grant_d;
    logic        w_grant_f;
    logic        w_unused_bits;

    // Fetches are always word accesses, so the low address bits carry nothing.
    assign w_unused_bits = &{1'b0, bus.if_addr[1:0]};

    // Lane steering: byte/half data is replicated so any lane sees it.
    always_comb begin
        w_st_be      = 4'b1111;
        w_st_wdata   = bus.d_wdata;
        w_misaligned = 1'b0;
        case (bus.d_size)
            2'b01: begin
                w_st_be    = 4'b0001 << bus.d_addr[1:0];
                w_st_wdata = {4{bus.d_wdata[7:0]}};
            end
            2'b10: begin
                w_st_be      = bus.d_addr[1] ? 4'b1100 : 4'b0011;
                w_st_wdata   = {2{bus.d_wdata[15:0]}};
                w_misaligned = bus.d_addr[0];
            end
            default: w_misaligned = |bus.d_addr[1:0];
        endcase
        if (!bus.d_we) begin
            w_st_be    = 4'b0000;
            w_st_wdata = 32'h0000_0000;
        end
    end

`ifdef MEM_ARB_RR_EN
    logic r_last_d, w_last_d_nxt;

    assign w_d_first = ~r_last_d;

    always_comb begin
        w_last_d_nxt = r_last_d;
        if (r_state == S_IDLE) begin
            if (w_grant_d)
                w_last_d_nxt = 1'b1;
            else if (w_grant_f)
                w_last_d_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_last_d <= 1'b0;
        else
            r_last_d <= w_last_d_nxt;
    end
`else
    assign w_d_first = 1'b1;
`endif

    assign w_grant_d = bus.d_req & (w_d_first | ~bus.if_req);
    assign w_grant_f = bus.if_req & ~w_grant_d;

    always_comb begin
        w_state_nxt     = r_state;
        w_mem_req_nxt   = r_mem_req;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_be_nxt    = r_mem_be;
        w_mem_wdata_nxt = r_mem_wdata;
        w_if_valid_nxt  = 1'b0;
        w_if_rdata_nxt  = r_if_rdata;
        w_d_valid_nxt   = 1'b0;
        w_d_rdata_nxt   = r_d_rdata;
        w_d_mis_nxt     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_d) begin
                    if (w_misaligned) begin
                        // Rejected locally: complete without touching memory.
                        w_d_valid_nxt = 1'b1;
                        w_d_mis_nxt   = 1'b1;
                        w_d_rdata_nxt = 32'h0000_0000;
                    end else begin
                        w_state_nxt     = S_DATA;
                        w_mem_req_nxt   = 1'b1;
                        w_mem_addr_nxt  = {bus.d_addr[31:2], 2'b00};
                        w_mem_be_nxt    = w_st_be;
                        w_mem_wdata_nxt = w_st_wdata;
                    end
                end else if (w_grant_f) begin
                    w_state_nxt     = S_FETCH;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_addr_nxt  = {bus.if_addr[31:2], 2'b00};
                    w_mem_be_nxt    = 4'b0000;
                    w_mem_wdata_nxt = 32'h0000_0000;
                end
            end
            S_FETCH: begin
                if (bus.mem_ack) begin
                    w_state_nxt    = S_IDLE;
                    w_mem_req_nxt  = 1'b0;
                    w_if_valid_nxt = 1'b1;
                    w_if_rdata_nxt = bus.mem_rdata;
                end
            end
            S_DATA: begin
                if (bus.mem_ack) begin
                    w_state_nxt   = S_IDLE;
                    w_mem_req_nxt = 1'b0;
                    w_d_valid_nxt = 1'b1;
                    w_d_rdata_nxt = bus.mem_rdata;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_mem_req_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= 32'h0000_0000;
            r_mem_be    <= 4'b0000;
            r_mem_wdata <= 32'h0000_0000;
            r_if_valid  <= 1'b0;
            r_if_rdata  <= 32'h0000_0000;
            r_d_valid   <= 1'b0;
            r_d_rdata   <= 32'h0000_0000;
            r_d_mis     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_be    <= w_mem_be_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_if_valid  <= w_if_valid_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_d_valid   <= w_d_valid_nxt;
            r_d_rdata   <= w_d_rdata_nxt;
            r_d_mis     <= w_d_mis_nxt;
        end
    end

    assign bus.mem_req      = r_mem_req;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_be       = r_mem_be;
    assign bus.mem_wdata    = r_mem_wdata;
    assign bus.if_valid     = r_if_valid;
    assign bus.if_rdata     = r_if_rdata;
    assign bus.d_valid      = r_d_valid;
    assign bus.d_rdata      = r_d_rdata;
    assign bus.d_misaligned = r_d_mis;
    assign bus.stall        = rst_n & ((bus.if_req & ~r_if_valid) | (bus.d_req & ~r_d_valid));

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arb.sv
// ============================================================================
// Module   : tb_mem_port_arb
// Brief    : Scoreboard bench for mem_port_arb with a queued memory model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_port_arb;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_port_arb_if bus();

    mem_port_arb dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } mem_t;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          cyc;
    } rsp_t;

    mem_t mem_q[$];
    rsp_t if_q[$];
    rsp_t d_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    int   ack_delay = 0;
    bit   mem_auto  = 1'b1;
    logic man_ack   = 1'b0;
    bit   in_txn    = 1'b0;
    int   wait_cnt  = 0;
    mem_t cur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: no response within bound", name);
    endtask

    always @(posedge clk) cyc++;

    // Memory model: checks each new request against the queue, then acks.
    always @(negedge clk) begin
        if (bus.mem_req === 1'b1) begin
            if (!in_txn) begin
                in_txn   = 1'b1;
                wait_cnt = 0;
                if (mem_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL mem_req_unexpected: got addr 0x%08h expected no request", bus.mem_addr);
                    cur = '{bus.mem_addr, bus.mem_be, bus.mem_wdata, 32'h0};
                end else begin
                    cur = mem_q.pop_front();
                    chk("mem_addr", bus.mem_addr, cur.addr);
                    chk("mem_be", {28'h0, bus.mem_be}, {28'h0, cur.be});
                    chk("mem_wdata", bus.mem_wdata, cur.wdata);
                end
            end else begin
                chk("mem_addr_hold", bus.mem_addr, cur.addr);
                chk("mem_be_hold", {28'h0, bus.mem_be}, {28'h0, cur.be});
            end
            if (mem_auto) begin
                if (wait_cnt >= ack_delay) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = cur.rdata;
                end else begin
                    bus.mem_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                bus.mem_ack   = man_ack;
                bus.mem_rdata = 32'hDEAD_BEEF;
            end
        end else begin
            in_txn        = 1'b0;
            bus.mem_ack   = mem_auto ? 1'b0 : man_ack;
            bus.mem_rdata = mem_auto ? 32'h0 : 32'hDEAD_BEEF;
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        rsp_t e;
        if (bus.if_valid === 1'b1) begin
            if (if_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL if_valid_unexpected: got pulse rdata 0x%08h expected none", bus.if_rdata);
            end else begin
                e = if_q.pop_front();
                chk("if_rdata", bus.if_rdata, e.rdata);
                if (e.cyc >= 0) chk("if_latency", cyc, e.cyc);
            end
        end
        if (bus.d_valid === 1'b1) begin
            if (d_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL d_valid_unexpected: got pulse rdata 0x%08h expected none", bus.d_rdata);
            end else begin
                e = d_q.pop_front();
                chk("d_rdata", bus.d_rdata, e.rdata);
                chk("d_misaligned", {31'h0, bus.d_misaligned}, {31'h0, e.mis});
                if (e.cyc >= 0) chk("d_latency", cyc, e.cyc);
            end
        end
    end

    task automatic wait_if(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (bus.if_valid === 1'b1) ok = 1'b1;
        end
        if (!ok) timeout(name);
        bus.if_req = 1'b0;
    endtask

    task automatic wait_d(input string name, input int count);
        int seen = 0;
        for (int i = 0; i < 100 && seen < count; i++) begin
            @(negedge clk);
            if (bus.d_valid === 1'b1) seen++;
        end
        if (seen < count) timeout(name);
        bus.d_req = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp_addr,
                            input logic [31:0] rdata, input int delay);
        @(negedge clk);
        ack_delay = delay;
        mem_q.push_back('{exp_addr, 4'b0000, 32'h0, rdata});
        if_q.push_back('{rdata, 1'b0, cyc + 2 + delay});
        bus.if_req  = 1'b1;
        bus.if_addr = addr;
        wait_if("fetch_wait");
    endtask

    task automatic do_data(input logic we, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic mis,
                           input logic [31:0] exp_addr, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata, input logic [31:0] rdata,
                           input int delay);
        @(negedge clk);
        ack_delay = delay;
        if (mis) begin
            d_q.push_back('{32'h0, 1'b1, cyc + 1});
        end else begin
            mem_q.push_back('{exp_addr, exp_be, exp_wdata, rdata});
            d_q.push_back('{rdata, 1'b0, cyc + 2 + delay});
        end
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_size  = size;
        bus.d_addr  = addr;
        bus.d_wdata = wdata;
        wait_d("data_wait", 1);
    endtask

    initial begin
        int nd;
        bit stall_done;
        bus.if_req  = 1'b0;
        bus.if_addr = 32'h0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_size  = 2'b11;
        bus.d_addr  = 32'h0;
        bus.d_wdata = 32'h0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        rst_n = 1'b0;

        // Reset state, with a pending fetch to show stall is held low.
        repeat (3) @(negedge clk);
        bus.if_req = 1'b1;
        @(negedge clk);
        chk("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_be", {28'h0, bus.mem_be}, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_if_valid", {31'h0, bus.if_valid}, 32'h0);
        chk("rst_d_valid", {31'h0, bus.d_valid}, 32'h0);
        chk("rst_d_misaligned", {31'h0, bus.d_misaligned}, 32'h0);
        chk("rst_if_rdata", bus.if_rdata, 32'h0);
        chk("rst_d_rdata", bus.d_rdata, 32'h0);
        chk("rst_stall", {31'h0, bus.stall}, 32'h0);
        bus.if_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Simultaneous fetch and load, data requester holds d_req.
        @(negedge clk);
        ack_delay = 0;
`ifdef MEM_ARB_RR_EN
        mem_q.push_back('{32'h0000_0200, 4'b0000, 32'h0, 32'hD000_0001});
        mem_q.push_back('{32'h0000_0100, 4'b0000, 32'h0, 32'hF000_0001});
        mem_q.push_back('{32'h0000_0200, 4'b0000, 32'h0, 32'hD000_0002});
        d_q.push_back('{32'hD000_0001, 1'b0, -1});
        d_q.push_back('{32'hD000_0002, 1'b0, -1});
        nd = 2;
`else
        mem_q.push_back('{32'h0000_0200, 4'b0000, 32'h0, 32'hD000_0001});
        mem_q.push_back('{32'h0000_0200, 4'b0000, 32'h0, 32'hD000_0002});
        mem_q.push_back('{32'h0000_0200, 4'b0000, 32'h0, 32'hD000_0003});
        mem_q.push_back('{32'h0000_0100, 4'b0000, 32'h0, 32'hF000_0001});
        d_q.push_back('{32'hD000_0001, 1'b0, -1});
        d_q.push_back('{32'hD000_0002, 1'b0, -1});
        d_q.push_back('{32'hD000_0003, 1'b0, -1});
        nd = 3;
`endif
        if_q.push_back('{32'hF000_0001, 1'b0, -1});
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0100;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_size  = 2'b11;
        bus.d_addr  = 32'h0000_0200;
        bus.d_wdata = 32'h0;
        stall_done  = 1'b0;
        fork
            wait_d("tie_data_wait", nd);
            wait_if("tie_fetch_wait");
            begin
                for (int i = 0; i < 100 && !stall_done; i++) begin
                    @(negedge clk);
                    if (bus.if_valid === 1'b1) stall_done = 1'b1;
                    else chk("stall_tie", {31'h0, bus.stall}, 32'h1);
                end
                if (!stall_done) timeout("stall_tie_wait");
            end
        join

        // Fetches: minimum latency, then ignored low bits with one wait state.
        do_fetch(32'h0000_0104, 32'h0000_0104, 32'h2408_0005, 0);
        do_fetch(32'h0000_0107, 32'h0000_0104, 32'h8C09_0000, 1);

        // Stores across sizes and lanes.
        do_data(1'b1, 2'b01, 32'h0000_0013, 32'h0000_00AB, 1'b0,
                32'h0000_0010, 4'b1000, 32'hABAB_ABAB, 32'h0, 2);
        do_data(1'b1, 2'b10, 32'h0000_0012, 32'h0000_1234, 1'b0,
                32'h0000_0010, 4'b1100, 32'h1234_1234, 32'h0, 0);
        do_data(1'b1, 2'b10, 32'h0000_0010, 32'hFFFF_5678, 1'b0,
                32'h0000_0010, 4'b0011, 32'h5678_5678, 32'h0, 0);
        do_data(1'b1, 2'b01, 32'h0000_0021, 32'h0000_00C3, 1'b0,
                32'h0000_0020, 4'b0010, 32'hC3C3_C3C3, 32'h0, 0);
        do_data(1'b1, 2'b11, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0,
                32'h0000_0040, 4'b1111, 32'hDEAD_BEEF, 32'h0, 0);
        do_data(1'b1, 2'b00, 32'h0000_0044, 32'h0102_0304, 1'b0,
                32'h0000_0044, 4'b1111, 32'h0102_0304, 32'h0, 1);

        // Loads return the raw word; write lanes stay off.
        do_data(1'b0, 2'b11, 32'h0000_0008, 32'h5555_5555, 1'b0,
                32'h0000_0008, 4'b0000, 32'h0, 32'hCAFE_F00D, 3);
        do_data(1'b0, 2'b01, 32'h0000_000B, 32'h0, 1'b0,
                32'h0000_0008, 4'b0000, 32'h0, 32'h1122_3344, 0);

        // Misaligned accesses complete locally with zero data.
        do_data(1'b0, 2'b11, 32'h0000_0006, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0, 0);
        do_data(1'b1, 2'b10, 32'h0000_0013, 32'h0000_1234, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0, 0);
        do_data(1'b0, 2'b10, 32'h0000_0001, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0, 0);
        do_data(1'b1, 2'b00, 32'h0000_0042, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0, 0);

        // Reset while memory stalls; a late ack must produce nothing.
        @(negedge clk);
        mem_auto = 1'b0;
        man_ack  = 1'b0;
        mem_q.push_back('{32'h0000_0300, 4'b0000, 32'h0, 32'h0});
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0300;
        repeat (5) begin
            @(negedge clk);
            chk("mem_req_waiting", {31'h0, bus.mem_req}, 32'h1);
        end
        rst_n      = 1'b0;
        bus.if_req = 1'b0;
        @(negedge clk);
        chk("mem_req_after_rst", {31'h0, bus.mem_req}, 32'h0);
        chk("stall_after_rst", {31'h0, bus.stall}, 32'h0);
        rst_n   = 1'b1;
        man_ack = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("late_ack_if_valid", {31'h0, bus.if_valid}, 32'h0);
            chk("late_ack_d_valid", {31'h0, bus.d_valid}, 32'h0);
            chk("late_ack_mem_req", {31'h0, bus.mem_req}, 32'h0);
        end
        man_ack  = 1'b0;
        mem_auto = 1'b1;

        // Recovery after the aborted transaction.
        do_fetch(32'h0000_0400, 32'h0000_0400, 32'h1357_9BDF, 0);

        repeat (3) @(negedge clk);
        chk("mem_q_drained", mem_q.size(), 32'h0);
        chk("if_q_drained", if_q.size(), 32'h0);
        chk("d_q_drained", d_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_port_arb.md
# mem_port_arb

Arbiter and sequencer for the single shared memory port between instruction fetch and the data load/store path of the pipelined MIPS core. It accepts one fetch requester and one data requester, grants one at a time, and drives a registered memory request held until the memory acknowledges. For stores it derives byte write enables and lane-replicated write data from the access size and low address bits, matching the SB/SH/SW mask encoding. It returns load words unmodified to the downstream LB/LH extension logic.

## Interface
- No parameters; all widths fixed at 32-bit address/data, 4 byte lanes.
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr stable until if_valid
- if_addr  in  32  fetch byte address; bits [1:0] ignored
- if_valid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  32  fetched word, registered
- d_req  in  1  data request; held with d_* stable until d_valid
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  01 byte, 10 half, 11 word; 00 treated as word
- d_addr  in  32  data byte address
- d_wdata  in  32  store data, right-justified
- d_valid  out  1  one-cycle pulse: data access complete
- d_rdata  out  32  loaded word, registered, unshifted
- d_misaligned  out  1  one-cycle pulse with d_valid on misaligned access
- mem_req  out  1  registered memory request
- mem_addr  out  32  word address: {addr[31:2], 2'b00}
- mem_be  out  4  byte write enables; 0000 for reads
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  memory completion; mem_rdata valid in same cycle
- mem_rdata  in  32  memory read word
- stall  out  1  (if_req & ~if_valid) | (d_req & ~d_valid); forced 0 while rst_n low

## Operation
- FSM states: IDLE, FETCH, DATA.
- IDLE: if d_req and (priority selects data), go to DATA; else if if_req, go to FETCH. On transition, register mem_req=1, mem_addr, mem_be, and mem_wdata.
- Fixed priority (default): data beats fetch on a tie.
- FETCH/DATA: hold all mem_* outputs stable. On an edge with mem_ack=1, capture mem_rdata into if_rdata or d_rdata, pulse the matching valid for the following cycle, clear mem_req, and return to IDLE.
- Store lanes (lane k = addr[1:0]==k):
  - Byte: mem_be = 4'b0001 << addr[1:0]; mem_wdata = {4{wdata[7:0]}}.
  - Half: mem_be = addr[1] ? 1100 : 0011; mem_wdata = {2{wdata[15:0]}}.
  - Word: mem_be = 1111; mem_wdata = wdata.
- Loads: mem_be = 0000; mem_wdata = 0.
- Misaligned accesses are half with addr[0]=1, or word with addr[1:0]≠00. On one:
  - No memory transaction is issued; FSM stays IDLE.
  - d_valid and d_misaligned pulse in the cycle after acceptance.
  - d_rdata is 0.
- mem_ack while mem_req=0 is ignored.
- Reset values: mem_req 0, mem_addr 0, mem_be 0, mem_wdata 0, if_valid 0, d_valid 0, d_misaligned 0, if_rdata 0, d_rdata 0, stall 0; FSM IDLE; last-grant flag = FETCH.

## Timing
- Request sampled at edge E0, granted → mem_req high in cycle E0..E1.
- mem_ack high at E1 → valid high in cycle E1..E2. Minimum latency is 2 cycles from request edge to valid.
- Each extra cycle of mem_ack=0 adds 1 cycle of latency; mem_req stays high and unchanged throughout.
- Back-to-back operation: FSM is IDLE during the valid cycle, so a request still high at E2 is a new request. The requester must drop req in the valid cycle unless it issues another access.
- The losing requester waits in IDLE arbitration, with no bubble beyond the winner's completion.
- Reset mid-transaction: at the reset edge the FSM returns to IDLE and mem_req drops. A late mem_ack is ignored and no valid is generated.

## Configuration
- MEM_ARB_RR_EN defined: on a tie in IDLE, grant the requester not granted last. The last-grant flag updates on every grant and resets to FETCH, so data wins the first tie after reset.
- MEM_ARB_RR_EN undefined: fixed data-over-fetch priority; the last-grant flag is not implemented.

## Test plan
- Fetch to 0x0000_0104 with mem_ack on the first request cycle, mem_rdata=0x2408_0005 → mem_addr=0x0000_0104, mem_be=0000; if_valid 2 cycles after request; if_rdata=0x2408_0005.
- SB d_addr=0x0000_0013, d_wdata=0x0000_00AB → mem_be=1000, mem_wdata=0xABAB_ABAB, mem_addr=0x0000_0010. SH at 0x0000_0012, d_wdata=0x1234 → mem_be=1100, mem_wdata=0x1234_1234.
- Word load at 0x0000_0006 → no mem_req; d_valid=1 and d_misaligned=1 the next cycle; d_rdata=0.
- if_req and d_req both high for 3 transactions:
  - Default build → D, D, D while d_req stays high; stall stays 1 until if_valid.
  - With MEM_ARB_RR_EN → D, F, D.
- mem_ack held low 5 cycles, then rst_n low for one edge → mem_req 0 and FSM IDLE after the edge. A subsequent mem_ack=1 gives no if_valid or d_valid pulse.
